// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, drives every datapath strobe and counts retires.
module multicycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_data,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             aluout_we,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic [WIDTH-1:0] instret,
    output logic             illegal,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_instret;
    logic             r_illegal;

    logic       w_memReq, w_memWe, w_memSel, w_irWe, w_mdrWe, w_aluoutWe;
    logic       w_aluSrcB, w_rfWe, w_pcWe, w_retire, w_supported;
    logic [1:0] w_aluOp, w_wbSel, w_pcSrc;
    logic [6:0] w_opcode;
    logic       w_unusedInstr;

    assign w_opcode      = instr[6:0];
    assign w_unusedInstr = &{1'b0, instr[WIDTH-1:7]};

    always_comb begin
        case (w_opcode)
            OP_RALU, OP_IALU, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: w_supported = 1'b1;
            default:                            w_supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instret <= r_instret + 1'b1;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_memReq   = 1'b0;
        w_memWe    = 1'b0;
        w_memSel   = 1'b0;
        w_irWe     = 1'b0;
        w_mdrWe    = 1'b0;
        w_aluoutWe = 1'b0;
        w_aluSrcB  = 1'b0;
        w_aluOp    = 2'b00;
        w_rfWe     = 1'b0;
        w_wbSel    = 2'b00;
        w_pcWe     = 1'b0;
        w_pcSrc    = 2'b00;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memReq = 1'b1;
                if (mem_ready) begin
                    w_irWe = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: w_next = w_supported ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (w_opcode)
                    OP_RALU, OP_IALU: begin
                        w_aluSrcB  = (w_opcode == OP_IALU);
                        w_aluOp    = 2'b10;
                        w_aluoutWe = 1'b1;
                        w_next     = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_aluSrcB  = 1'b1;
                        w_aluoutWe = 1'b1;
                        w_next     = S_MEM;
                    end
                    OP_BRANCH: begin
                        w_aluOp  = 2'b01;
                        w_pcWe   = 1'b1;
                        w_pcSrc  = branch_taken ? 2'b01 : 2'b00;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        w_aluSrcB = (w_opcode == OP_JALR);
                        w_rfWe    = 1'b1;
                        w_wbSel   = 2'b10;
                        w_pcWe    = 1'b1;
                        w_pcSrc   = (w_opcode == OP_JALR) ? 2'b10 : 2'b01;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    OP_LUI: begin
                        w_rfWe   = 1'b1;
                        w_wbSel  = 2'b11;
                        w_pcWe   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    // IR changed under us after DECODE accepted it.
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                w_memReq = 1'b1;
                w_memSel = 1'b1;
                w_memWe  = (w_opcode == OP_STORE);
                if (mem_ready) begin
                    if (w_opcode == OP_STORE) begin
                        w_pcWe   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_mdrWe = 1'b1;
                        w_next  = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rfWe   = 1'b1;
                w_wbSel  = (w_opcode == OP_LOAD) ? 2'b01 : 2'b00;
                w_pcWe   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset must silence everything at once, including the FETCH request.
    assign mem_req      = rst_n & w_memReq;
    assign mem_we       = rst_n & w_memWe;
    assign mem_sel_data = rst_n & w_memSel;
    assign ir_we        = rst_n & w_irWe;
    assign mdr_we       = rst_n & w_mdrWe;
    assign aluout_we    = rst_n & w_aluoutWe;
    assign alu_src_b    = rst_n & w_aluSrcB;
    assign alu_op       = rst_n ? w_aluOp : 2'b00;
    assign rf_we        = rst_n & w_rfWe;
    assign wb_sel       = rst_n ? w_wbSel : 2'b00;
    assign pc_we        = rst_n & w_pcWe;
    assign pc_src       = rst_n ? w_pcSrc : 2'b00;
    assign instr_done   = rst_n & w_retire;
    assign instret      = rst_n ? r_instret : '0;
    assign illegal      = rst_n & r_illegal;
    assign state_dbg    = rst_n ? 3'(r_state) : 3'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its phases cycle by cycle against hand-derived strobe and select values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_sel_data, ir_we, mdr_we, aluout_we;
    logic        alu_src_b, rf_we, pc_we, instr_done, illegal;
    logic [1:0]  alu_op, wb_sel, pc_src;
    logic [31:0] instret;
    logic [2:0]  state_dbg;
    logic [9:0]  strobes;
    logic [6:0]  sels;
    int          checks;
    int          errors;

    multicycle_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel_data(mem_sel_data), .ir_we(ir_we), .mdr_we(mdr_we),
        .aluout_we(aluout_we), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
        .instr_done(instr_done), .instret(instret), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    // Strobe order: mem_req mem_we mem_sel ir mdr aluout rf pc done illegal
    assign strobes = {mem_req, mem_we, mem_sel_data, ir_we, mdr_we, aluout_we,
                      rf_we, pc_we, instr_done, illegal};
    // Select order: alu_src_b alu_op wb_sel pc_src
    assign sels    = {alu_src_b, alu_op, wb_sel, pc_src};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] newInstr);
        instr = newInstr;
    endtask

    // Drives one cycle's inputs at the falling edge, checks, then advances.
    task automatic cycleCheck(input string tag, input logic ready, input logic taken,
                              input logic [2:0] expState, input logic [9:0] expStrobe,
                              input logic [6:0] expSel, input logic [6:0] selMask);
        mem_ready    = ready;
        branch_taken = taken;
        #1;
        checkOutput({tag, "/state"}, 32'(state_dbg), 32'(expState));
        checkOutput({tag, "/strobe"}, 32'(strobes), 32'(expStrobe));
        if (selMask != 7'd0)
            checkOutput({tag, "/sel"}, 32'(sels & selMask), 32'(expSel));
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [9:0] ST_NONE  = 10'b0000000000;
    localparam logic [9:0] ST_FWAIT = 10'b1000000000;
    localparam logic [9:0] ST_FETCH = 10'b1001000000;
    localparam logic [9:0] ST_ALU   = 10'b0000010000;
    localparam logic [9:0] ST_RET   = 10'b0000001110;
    localparam logic [9:0] ST_BR    = 10'b0000000110;

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        instr        = 32'h0;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;

        @(negedge clk);
        #1;
        checkOutput("reset/strobe", 32'(strobes), 32'h0);
        checkOutput("reset/state", 32'(state_dbg), 32'h0);
        checkOutput("reset/instret", instret, 32'h0);
        rst_n = 1'b1;

        applyStimulus(32'h00500093);
        cycleCheck("addi/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("addi/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("addi/exec", 1'b1, 1'b0, 3'd2, ST_ALU, 7'b1100000, 7'b1110000);
        cycleCheck("addi/wb", 1'b1, 1'b0, 3'd4, ST_RET, 7'b0000000, 7'b0001111);
        checkOutput("addi/instret", instret, 32'd1);

        applyStimulus(32'h0000A103);
        cycleCheck("lw/fetch0", 1'b0, 1'b0, 3'd0, ST_FWAIT, 7'h00, 7'h00);
        cycleCheck("lw/fetch1", 1'b0, 1'b0, 3'd0, ST_FWAIT, 7'h00, 7'h00);
        cycleCheck("lw/fetch2", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("lw/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("lw/exec", 1'b1, 1'b0, 3'd2, ST_ALU, 7'b1000000, 7'b1110000);
        cycleCheck("lw/mem0", 1'b0, 1'b0, 3'd3, 10'b1010000000, 7'h00, 7'h00);
        cycleCheck("lw/mem1", 1'b0, 1'b0, 3'd3, 10'b1010000000, 7'h00, 7'h00);
        cycleCheck("lw/mem2", 1'b1, 1'b0, 3'd3, 10'b1010100000, 7'h00, 7'h00);
        cycleCheck("lw/wb", 1'b1, 1'b0, 3'd4, ST_RET, 7'b0000100, 7'b0001111);
        checkOutput("lw/instret", instret, 32'd2);

        applyStimulus(32'h00000063);
        cycleCheck("beqT/fetch", 1'b1, 1'b1, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("beqT/decode", 1'b1, 1'b1, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("beqT/exec", 1'b1, 1'b1, 3'd2, ST_BR, 7'b0010001, 7'b1110011);
        cycleCheck("beqN/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("beqN/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("beqN/exec", 1'b1, 1'b0, 3'd2, ST_BR, 7'b0010000, 7'b1110011);
        checkOutput("beq/instret", instret, 32'd4);

        applyStimulus(32'h008000EF);
        cycleCheck("jal/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("jal/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("jal/exec", 1'b1, 1'b0, 3'd2, ST_RET, 7'b0001001, 7'b0001111);
        checkOutput("jal/instret", instret, 32'd5);

        applyStimulus(32'h123450B7);
        cycleCheck("lui/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("lui/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("lui/exec", 1'b1, 1'b0, 3'd2, ST_RET, 7'b0001100, 7'b0001111);

        applyStimulus(32'h000080E7);
        cycleCheck("jalr/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("jalr/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("jalr/exec", 1'b1, 1'b0, 3'd2, ST_RET, 7'b1001010, 7'b1111111);

        applyStimulus(32'h002081B3);
        cycleCheck("add/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("add/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("add/exec", 1'b1, 1'b0, 3'd2, ST_ALU, 7'b0100000, 7'b1110000);
        cycleCheck("add/wb", 1'b1, 1'b0, 3'd4, ST_RET, 7'b0000000, 7'b0001111);

        applyStimulus(32'h0020A023);
        cycleCheck("sw/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("sw/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("sw/exec", 1'b1, 1'b0, 3'd2, ST_ALU, 7'b1000000, 7'b1110000);
        cycleCheck("sw/mem", 1'b1, 1'b0, 3'd3, 10'b1110000110, 7'b0000000, 7'b0000011);
        checkOutput("sw/instret", instret, 32'd9);

        // Second store is abandoned by reset while memory stalls.
        cycleCheck("swR/fetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("swR/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        cycleCheck("swR/exec", 1'b1, 1'b0, 3'd2, ST_ALU, 7'b1000000, 7'b1110000);
        cycleCheck("swR/mem0", 1'b0, 1'b0, 3'd3, 10'b1110000000, 7'h00, 7'h00);
        mem_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("swR/rstStrobe", 32'(strobes), 32'h0);
        checkOutput("swR/rstSel", 32'(sels), 32'h0);
        checkOutput("swR/rstState", 32'(state_dbg), 32'h0);
        checkOutput("swR/rstInstret", instret, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycleCheck("swR/refetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);

        applyStimulus(32'h0000007F);
        cycleCheck("ill/decode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);
        for (int i = 0; i < 20; i++)
            cycleCheck($sformatf("ill/trap%0d", i), 1'b1, 1'b0, 3'd7, 10'b0000000001,
                       7'h00, 7'h00);
        checkOutput("ill/instret", instret, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ill/rstIllegal", 32'(illegal), 32'h0);
        checkOutput("ill/rstState", 32'(state_dbg), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h00500093);
        cycleCheck("ill/refetch", 1'b1, 1'b0, 3'd0, ST_FETCH, 7'h00, 7'h00);
        cycleCheck("ill/redecode", 1'b1, 1'b0, 3'd1, ST_NONE, 7'h00, 7'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
